// File: rtl/div_issue_ctrl.sv
// EX-stage divide issue controller: launches DIV/DIVU into the pipelined divider, stalls ID/EX while in flight,
// captures quotient/remainder into LO/HI and hands them to WB. Optional zero-divisor bypass: DIV_ZERO_BYPASS_EN.
module div_issue_ctrl #(
  parameter int LATENCY       = 17,
  parameter int TIMEOUT_SLACK = 4,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_is_signed,
  input  logic [31:0] id_dividend,
  input  logic [31:0] id_divisor,
  input  logic        wb_allin,
  output logic        div_ce,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_flush,
  input  logic        div_ce_ret,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        ex_stall_req,
  output logic        hilo_we,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out,
  output logic        busy,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  // Handshake: ID may present a divide only when ex_stall_req is low at the end of the
  // cycle; WB consumes lo_out/hi_out in the cycle hilo_we is high (wb_allin was high the cycle before).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(LATENCY + TIMEOUT_SLACK);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             launch, bypass, capture, we_nxt, timeout, zero_div;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_div = (id_divisor == 32'd0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    bypass    = 1'b0;
    capture   = 1'b0;
    we_nxt    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (id_valid && !flush) begin
          if (zero_div) begin
            bypass    = 1'b1;
            state_nxt = HOLD;
          end else begin
            launch    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = flush ? IDLE : WAIT;
      WAIT: begin
        // Flush outranks a same-cycle return: the result is discarded.
        if (flush) begin
          state_nxt = IDLE;
        end else if (div_ce_ret) begin
          capture = 1'b1;
          if (wb_allin) begin
            we_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end else if (count == TO_CNT) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (wb_allin) begin
          we_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      hilo_we      <= 1'b0;
      lo_out       <= 32'd0;
      hi_out       <= 32'd0;
      div_signed   <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else begin
      state   <= state_nxt;
      hilo_we <= we_nxt;
      if (state == ISSUE) begin
        count <= '0;
      end else if (state == WAIT && count != CNT_MAX) begin
        count <= count + 1'b1;
      end
      if (launch) begin
        div_signed   <= id_is_signed;
        div_dividend <= id_dividend;
        div_divisor  <= id_divisor;
      end
      if (capture) begin
        lo_out <= div_quotient;
        hi_out <= div_remainder;
      end else if (bypass) begin
        lo_out <= 32'hFFFF_FFFF;
        hi_out <= id_dividend;
      end
    end
  end

  assign div_ce       = (state == ISSUE);
  assign div_flush    = (flush && state != IDLE) || timeout;
  assign err_timeout  = timeout;
  assign ex_stall_req = (state == IDLE) ? id_valid : 1'b1;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: negedge-driven stimulus, a behavioural divider with programmable return,
// and a monitor that pops expected {hi,lo} pairs whenever hilo_we fires.
module tb_div_issue_ctrl;

  logic        clk, reset, flush, id_valid, id_is_signed, wb_allin;
  logic [31:0] id_dividend, id_divisor;
  logic        div_ce, div_signed, div_flush, div_ce_ret;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic        ex_stall_req, hilo_we, busy, err_timeout;
  logic [31:0] lo_out, hi_out;
  logic [1:0]  dbg_state;

  div_issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_valid(id_valid), .id_is_signed(id_is_signed),
    .id_dividend(id_dividend), .id_divisor(id_divisor), .wb_allin(wb_allin),
    .div_ce(div_ce), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_flush(div_flush),
    .div_ce_ret(div_ce_ret), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .ex_stall_req(ex_stall_req), .hilo_we(hilo_we), .lo_out(lo_out), .hi_out(hi_out),
    .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int ce_cnt = 0, we_cnt = 0, we_cyc = 0, err_cnt = 0, err_cyc = 0, dfl_cnt = 0, dfl_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- divider model ----------------
  logic        model_en = 1'b0;
  int          model_lat = 17;
  logic [31:0] model_q = 32'd0, model_r = 32'd0;
  int          ret_at = -1;

  initial begin
    div_ce_ret    = 1'b0;
    div_quotient  = 32'd0;
    div_remainder = 32'd0;
  end

  always begin
    @(negedge clk);
    if (div_ce && model_en) ret_at = cyc + model_lat;
    if (cyc == ret_at) begin
      div_ce_ret    = 1'b1;
      div_quotient  = model_q;
      div_remainder = model_r;
    end else begin
      div_ce_ret = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always begin
    logic [63:0] exp;
    @(negedge clk);
    #1;
    if (reset) begin
      if (div_ce) ce_cnt++;
      if (err_timeout) begin err_cnt++; err_cyc = cyc; end
      if (div_flush) begin dfl_cnt++; dfl_cyc = cyc; end
      if (hilo_we) begin
        we_cnt++;
        we_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hilo_we actual=1 expected=0 lo=%0h hi=%0h (cycle %0d)", lo_out, hi_out, cyc);
        end else begin
          exp = exp_q.pop_front();
          check("hilo_result", {hi_out, lo_out}, exp);
          check("stall_low_at_we", 64'(ex_stall_req), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    id_valid     = 1'b1;
    id_is_signed = sgn;
    id_dividend  = a;
    id_divisor   = b;
  endtask

  task automatic wait_we(input int base, input int budget);
    int n;
    n = 0;
    while (we_cnt == base && n < budget) begin
      tick();
      n++;
    end
    if (we_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL hilo_we_wait actual=none expected=pulse within %0d cycles", budget);
    end
  endtask

  // ---------------- directed tests ----------------
  int c0, ce0, we0, e0, d0, w_cyc;

  initial begin
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0; id_is_signed = 1'b0;
    id_dividend = 32'd0; id_divisor = 32'd0; wb_allin = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", 64'({div_ce, div_flush, ex_stall_req, hilo_we, busy, err_timeout, div_signed}), 64'd0);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    check("reset_opnd", {div_dividend, div_divisor}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // DIVU 100/7
    c0 = cyc; ce0 = ce_cnt; we0 = we_cnt;
    model_en = 1'b1; model_lat = 17; model_q = 32'd14; model_r = 32'd2;
    wb_allin = 1'b1;
    issue(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    tick();
    id_valid = 1'b0;
    check("t1_ce", 64'(div_ce), 64'd1);
    check("t1_stall", 64'(ex_stall_req), 64'd1);
    check("t1_opnd", {div_dividend, div_divisor}, {32'd100, 32'd7});
    wait_we(we0, 40);
    check("t1_latency", 64'(we_cyc - c0), 64'd19);
    check("t1_ce_once", 64'(ce_cnt - ce0), 64'd1);
    check("t1_idle_after", 64'({busy, ex_stall_req}), 64'd0);

    // DIV -7/2 signed, new ID traffic while busy must be ignored
    tick();
    c0 = cyc; ce0 = ce_cnt; we0 = we_cnt;
    model_q = 32'hFFFF_FFFD; model_r = 32'hFFFF_FFFF;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    check("t2_signed", 64'(div_signed), 64'd1);
    issue(1'b0, 32'hDEAD_BEEF, 32'd5);
    repeat (8) tick();
    id_valid = 1'b0;
    check("t2_opnd_stable", {31'd0, div_signed, div_dividend, div_divisor}, {31'd0, 1'b1, 32'hFFFF_FFF9, 32'd2});
    wait_we(we0, 40);
    check("t2_latency", 64'(we_cyc - c0), 64'd19);
    check("t2_ce_once", 64'(ce_cnt - ce0), 64'd1);

    // DIVU 53/10 with WB blocked for 5 cycles after the return
    tick();
    c0 = cyc; we0 = we_cnt;
    wb_allin = 1'b0;
    model_q = 32'd5; model_r = 32'd3;
    issue(1'b0, 32'd53, 32'd10);
    exp_q.push_back({32'd3, 32'd5});
    tick();
    id_valid = 1'b0;
    repeat (18) tick();
    check("t3_hold_state", 64'(dbg_state), 64'd3);
    check("t3_hold_vals", {hi_out, lo_out}, {32'd3, 32'd5});
    check("t3_no_we_yet", 64'(we_cnt - we0), 64'd0);
    repeat (4) tick();
    check("t3_still_hold", 64'({dbg_state, ex_stall_req}), 64'({2'd3, 1'b1}));
    wb_allin = 1'b1;
    w_cyc = cyc;
    wait_we(we0, 10);
    check("t3_we_on_allin", 64'(we_cyc - w_cyc), 64'd1);
    repeat (3) tick();
    check("t3_we_single", 64'(we_cnt - we0), 64'd1);

    // flush at WAIT count=8, later stray return ignored
    c0 = cyc; we0 = we_cnt;
    model_q = 32'd9; model_r = 32'd9;
    issue(1'b0, 32'd81, 32'd9);
    tick();
    id_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    check("t4_div_flush", 64'(div_flush), 64'd1);
    tick();
    flush = 1'b0;
    check("t4_idle", 64'({dbg_state, busy}), 64'd0);
    repeat (10) tick();
    check("t4_no_we", 64'(we_cnt - we0), 64'd0);
    check("t4_hilo_kept", {hi_out, lo_out}, {32'd3, 32'd5});

    // flush in the same cycle as the divider return
    we0 = we_cnt;
    model_q = 32'd77; model_r = 32'd7;
    issue(1'b0, 32'd546, 32'd7);
    tick();
    id_valid = 1'b0;
    repeat (17) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    check("t5_flush_prio", {31'd0, busy, 32'(we_cnt - we0)}, 64'd0);
    check("t5_hilo_kept", {hi_out, lo_out}, {32'd3, 32'd5});

    // divider never returns
    c0 = cyc; we0 = we_cnt; e0 = err_cnt; d0 = dfl_cnt;
    model_en = 1'b0;
    issue(1'b0, 32'd10, 32'd3);
    tick();
    id_valid = 1'b0;
    repeat (21) tick();
    check("t6_busy_before", 64'(busy), 64'd1);
    repeat (2) tick();
    check("t6_busy_after", 64'(busy), 64'd0);
    tick();
    check("t6_err_once", 64'(err_cnt - e0), 64'd1);
    check("t6_err_cycle", 64'(err_cyc - c0), 64'd23);
    check("t6_flush_cycle", 64'(dfl_cyc - c0), 64'd23);
    check("t6_flush_once", 64'(dfl_cnt - d0), 64'd1);
    check("t6_no_we", 64'(we_cnt - we0), 64'd0);

    // zero divisor
    tick();
    c0 = cyc; ce0 = ce_cnt; we0 = we_cnt;
    model_en = 1'b1; model_q = 32'hFFFF_FFFF; model_r = 32'h0000_1234;
    issue(1'b0, 32'h0000_1234, 32'd0);
    exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    tick();
    id_valid = 1'b0;
    wait_we(we0, 40);
`ifdef DIV_ZERO_BYPASS_EN
    check("t7_zero_latency", 64'(we_cyc - c0), 64'd2);
    check("t7_zero_no_ce", 64'(ce_cnt - ce0), 64'd0);
`else
    check("t7_zero_latency", 64'(we_cyc - c0), 64'd19);
    check("t7_zero_ce", 64'(ce_cnt - ce0), 64'd1);
`endif

    // id_valid with flush in IDLE: no launch
    repeat (2) tick();
    ce0 = ce_cnt;
    issue(1'b0, 32'd9, 32'd3);
    flush = 1'b1;
    #1;
    check("t8_idle_flush_out", 64'({div_flush, ex_stall_req}), 64'b01);
    tick();
    id_valid = 1'b0;
    flush = 1'b0;
    check("t8_no_launch", 64'({dbg_state, busy}), 64'd0);
    repeat (2) tick();
    check("t8_no_ce", 64'(ce_cnt - ce0), 64'd0);

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
